store_narrow_rmw: RTL and testbench
===================================

# store_narrow_rmw

Data-memory store unit for the MEM stage. It narrows 32-bit register store data to byte, halfword or word width, which is the inverse of immediate/load sign extension. It places the narrowed value in the addressed byte lane and writes it to word-organised data memory. Sub-word stores use a read-modify-write sequence, and the unit stalls the pipeline while it is busy.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: memory word width; fixed at 32 for this design.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a store request is presented.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_addr` in `ADDR_W`: byte address.
- `req_data` in 32: register source data, before narrowing.
- `req_size` in 2: `00` = byte, `01` = half, `10` = word; `11` is reserved and treated as misaligned.
- `stall` out 1: equals `~req_ready`; driven to the hazard unit.
- `done` out 1: one-cycle pulse in the cycle the memory write is issued.
- `misalign_err` out 1: one-cycle pulse; the request was dropped.
- `mem_rd_en` out 1: synchronous read strobe.
- `mem_wr_en` out 1: write strobe.
- `mem_addr` out `ADDR_W-2`: word address, equal to `req_addr[ADDR_W-1:2]`.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: read data, valid the cycle after `mem_rd_en`.
- `mem_be` out 4: byte write enables; present only with `MEM_BYTE_WE_EN` defined.

## Operation
- Handshake: a request is accepted when `req_valid && req_ready`. Address, data and size are latched on acceptance. Requests presented while `req_ready` is low are ignored; the requester must hold them.
- Narrowing:
  - Byte store uses `req_data[7:0]`.
  - Half store uses `req_data[15:0]`.
  - Upper bits of `req_data` are discarded.
- Lane placement, little-endian:
  - Byte at offset k (`req_addr[1:0]` = k) occupies `wdata[8k+7:8k]`.
  - Half at `req_addr[1]` = h occupies `wdata[16h+15:16h]`.
- Alignment:
  - Half requires `addr[0]` = 0.
  - Word requires `addr[1:0]` = 0.
  - Any violation, or `req_size` = `11`, goes to ERR: no memory access, `misalign_err` pulses.
- States:
  - IDLE: `req_ready` = 1. On accept, go to ERR if misaligned, WRITE if word, READ if sub-word.
  - READ: `mem_rd_en` = 1, `mem_addr` = latched word address. Go to MERGE.
  - MERGE: capture `mem_rdata` with the narrowed lane replaced into register `wbuf`. Go to WRITE.
  - WRITE: `mem_wr_en` = 1, `mem_wdata` = `wbuf` (or the lane-placed data for a word store), `done` = 1. Go to IDLE.
  - ERR: `misalign_err` = 1. Go to IDLE.
- All memory and status outputs are Moore outputs decoded from state and registers. `mem_wdata` and `mem_addr` are don't-care when no strobe is high but are held stable.

## Timing
- Acceptance is cycle 0.
- Word store: WRITE in cycle 1; `req_ready` returns high in cycle 2. Throughput is one word store per 2 cycles.
- Sub-word store: READ in cycle 1, MERGE in cycle 2, WRITE in cycle 3; `req_ready` high in cycle 4.
- Misaligned store: ERR in cycle 1; `req_ready` high in cycle 2.
- Reset values: state IDLE, `wbuf` = 0, `req_ready` = 1 (0 while `rst` is high), and `stall`, `done`, `misalign_err`, `mem_rd_en`, `mem_wr_en` all 0. `mem_addr`, `mem_wdata` and `mem_be` are 0.
- Reset mid-operation (READ or MERGE): the store is abandoned and no write is issued. Strobes are low in the cycle after `rst` is sampled.
- `rst` and `req_valid` high in the same cycle: reset wins and the request is not accepted.
- A new request may be presented in the same cycle WRITE or ERR is active; it is accepted one cycle later, in IDLE.

## Configuration
- `MEM_BYTE_WE_EN` defined:
  - `mem_be` port exists.
  - Sub-word stores skip READ and MERGE and go IDLE→WRITE with `mem_be` selecting lanes (byte `0001<<k`, half `0011<<2h`, word `1111`), for 2-cycle latency on all sizes.
  - `mem_rd_en` is always 0.
  - `mem_be` is 0 outside WRITE.
- `MEM_BYTE_WE_EN` undefined: no `mem_be` port; the read-modify-write path described above is used.

## Structure
- Shared package `store_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State encodings `ST_IDLE`, `ST_READ`, `ST_MERGE`, `ST_WRITE`, `ST_ERR`.
  - Misalignment predicate.
- Sub-module `store_lane_merge`, combinational:
  - Inputs: `old_word`, `data`, `size`, `offset`.
  - Outputs: merged word and a 4-bit lane mask.
  - Used for both the `wbuf` capture and the `mem_be` derivation.

## Test plan
- Preload memory word 0x4 = `AABBCCDD`. Byte store at `0x13` with data `12345678` → `mem_rd_en` in cycle 1; write in cycle 3 of `78BBCCDD` to word address `0x4`; `done` pulses once.
- Same preload. Half store at `0x12` with data `0000BEEF` → `BEEFCCDD` written in cycle 3.
- Word store at `0x14` with data `DEADBEEF` → `mem_rd_en` never asserted; write in cycle 1; `req_ready` high in cycle 2.
- Half store at `0x11` → `misalign_err` in cycle 1; no `mem_rd_en` or `mem_wr_en`; memory unchanged.
- Byte store with `rst` asserted in the READ cycle → no `mem_wr_en` in any later cycle; outputs at reset values; next request accepted normally.
- With `MEM_BYTE_WE_EN` defined, byte store at `0x11` with data `000000AB` → write in cycle 1 with `mem_be` = `0010`, `mem_wdata[15:8]` = `AB`, no read.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings and alignment rule for the MEM-stage store unit.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // The reserved size code is treated as misaligned, so it never reaches memory.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Places narrowed store data into its little-endian byte lane over an old word,
// and reports which lanes were replaced.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged,
  output logic [3:0]  lane_mask
);

  always_comb begin
    merged    = old_word;
    lane_mask = 4'b0000;
    case (size)
      SZ_BYTE: begin
        merged[8*offset +: 8] = data[7:0];
        lane_mask             = 4'b0001 << offset;
      end
      SZ_HALF: begin
        merged[16*offset[1] +: 16] = data[15:0];
        lane_mask                  = 4'b0011 << {offset[1], 1'b0};
      end
      SZ_WORD: begin
        merged    = data;
        lane_mask = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// MEM-stage store unit: narrows register data to byte/half/word and writes it to
// word-organised memory via read-modify-write, or via byte enables when MEM_BYTE_WE_EN is defined.
module store_narrow_rmw
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              stall,
  output logic              done,
  output logic              misalign_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_BYTE_WE_EN
  ,
  output logic [3:0]        mem_be
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        offset_q, offset_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;

  logic              in_merge;
  logic [31:0]       m_old, m_data, merged;
  logic [1:0]        m_size, m_offset;
  logic [3:0]        lane_mask;

  // One merger serves both the live request (IDLE) and the latched request (MERGE).
  assign in_merge = (state_q == ST_MERGE);
  assign m_old    = in_merge ? mem_rdata : '0;
  assign m_data   = in_merge ? data_q    : req_data;
  assign m_size   = in_merge ? size_q    : req_size;
  assign m_offset = in_merge ? offset_q  : req_addr[1:0];

  store_lane_merge u_merge (
    .old_word  (m_old),
    .data      (m_data),
    .size      (m_size),
    .offset    (m_offset),
    .merged    (merged),
    .lane_mask (lane_mask)
  );

`ifdef MEM_BYTE_WE_EN
  logic [3:0] be_q, be_d;
`else
  logic unused_mask;
  assign unused_mask = ^lane_mask;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    size_d   = size_q;
    offset_d = offset_q;
    wbuf_d   = wbuf_q;
`ifdef MEM_BYTE_WE_EN
    be_d     = be_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[ADDR_W-1:2];
          data_d   = req_data;
          size_d   = req_size;
          offset_d = req_addr[1:0];
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = ST_ERR;
          end
`ifdef MEM_BYTE_WE_EN
          else begin
            state_d = ST_WRITE;
            wbuf_d  = merged;
            be_d    = lane_mask;
          end
`else
          else if (req_size == SZ_WORD) begin
            state_d = ST_WRITE;
            wbuf_d  = merged;
          end else begin
            state_d = ST_READ;
          end
`endif
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: begin
        wbuf_d  = merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      offset_q <= '0;
      wbuf_q   <= '0;
`ifdef MEM_BYTE_WE_EN
      be_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      size_q   <= size_d;
      offset_q <= offset_d;
      wbuf_q   <= wbuf_d;
`ifdef MEM_BYTE_WE_EN
      be_q     <= be_d;
`endif
    end
  end

  assign req_ready    = (state_q == ST_IDLE) && !rst;
  assign stall        = ~req_ready;
  assign done         = (state_q == ST_WRITE);
  assign mem_wr_en    = (state_q == ST_WRITE);
  assign misalign_err = (state_q == ST_ERR);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wbuf_q;
`ifdef MEM_BYTE_WE_EN
  assign mem_rd_en    = 1'b0;
  assign mem_be       = (state_q == ST_WRITE) ? be_q : 4'b0000;
`else
  assign mem_rd_en    = (state_q == ST_READ);
`endif

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Randomised self-checking bench for store_narrow_rmw against a word-array memory reference.
module tb_store_narrow_rmw;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, stall, done, misalign_err, mem_rd_en, mem_wr_en;
  logic [31:0] req_addr, req_data, mem_wdata, mem_rdata;
  logic [1:0]  req_size;
  logic [29:0] mem_addr;
`ifdef MEM_BYTE_WE_EN
  logic [3:0]  mem_be;
  localparam bit BE_MODE = 1'b1;
`else
  localparam bit BE_MODE = 1'b0;
`endif

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_narrow_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_size     (req_size),
    .stall        (stall),
    .done         (done),
    .misalign_err (misalign_err),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
`ifdef MEM_BYTE_WE_EN
    ,
    .mem_be       (mem_be)
`endif
  );

  // Synchronous data memory seen by the unit.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
    if (mem_wr_en) begin
`ifdef MEM_BYTE_WE_EN
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[3:0]][8*b +: 8] = mem_wdata[8*b +: 8];
`else
      mem[mem_addr[3:0]] = mem_wdata;
`endif
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refStore(input logic [31:0] old, input logic [31:0] data,
                                           input logic [1:0] size, input logic [1:0] off);
    int sh;
    if (size == 2'd0) begin
      sh = 8 * int'(off);
      return (old & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
    end else if (size == 2'd1) begin
      sh = 16 * int'(off[1]);
      return (old & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
    end
    return data;
  endfunction

  function automatic logic [3:0] refBe(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << (2 * int'(off[1])));
    return 4'hF;
  endfunction

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input string tag);
    logic        mis;
    int          w, wc, rc, readyc;
    logic [31:0] newword, mask32;
    logic [3:0]  be;
    logic [5:0]  got_v, exp_v;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    w   = int'(addr[5:2]);
    newword = mis ? ref_mem[w] : refStore(ref_mem[w], data, size, addr[1:0]);
    be      = refBe(size, addr[1:0]);
    mask32  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wc      = mis ? 0 : ((size == 2'd2 || BE_MODE) ? 1 : 3);
    rc      = (!mis && size != 2'd2 && !BE_MODE) ? 1 : 0;
    readyc  = mis ? 2 : wc + 1;
    checkOutput({tag, "_ready0"}, 64'(req_ready), 64'd1);
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp_v = {c == rc, c == wc, c == wc, mis && c == 1, c >= readyc, !(c >= readyc)};
      got_v = {mem_rd_en, mem_wr_en, done, misalign_err, req_ready, stall};
      checkOutput($sformatf("%s_c%0d_ctl", tag, c), 64'(got_v), 64'(exp_v));
      if (c == rc || c == wc)
        checkOutput($sformatf("%s_c%0d_addr", tag, c), 64'(mem_addr), 64'(addr >> 2));
`ifdef MEM_BYTE_WE_EN
      checkOutput($sformatf("%s_c%0d_be", tag, c), 64'(mem_be), 64'(c == wc ? be : 4'h0));
      if (c == wc)
        checkOutput({tag, "_wdata"}, 64'(mem_wdata & mask32), 64'(newword & mask32));
`else
      if (c == wc)
        checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'(newword));
`endif
      @(posedge clk);
      #1;
    end
    ref_mem[w] = newword;
    checkOutput({tag, "_mem"}, 64'(mem[w]), 64'(ref_mem[w]));
  endtask

`ifndef MEM_BYTE_WE_EN
  task automatic resetDuringRead();
    logic [5:0] got_v;
    req_addr = 32'h22; req_data = 32'h5A5A5A5A; req_size = 2'd0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checkOutput("rstmid_rd", 64'(mem_rd_en), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    got_v = {mem_rd_en, mem_wr_en, done, misalign_err, req_ready, stall};
    checkOutput("rstmid_ctl", 64'(got_v), 64'b000010);
    checkOutput("rstmid_addr", 64'(mem_addr), 64'd0);
    checkOutput("rstmid_wdata", 64'(mem_wdata), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 checkOutput($sformatf("rstmid_nowr%0d", c), 64'(mem_wr_en), 64'd0);
    end
    checkOutput("rstmid_mem", 64'(mem[8]), 64'(ref_mem[8]));
  endtask
`endif

  task automatic resetWithRequest();
    logic [5:0] got_v;
    rst = 1'b1; req_addr = 32'h20; req_data = 32'hCAFEF00D; req_size = 2'd2; req_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    #1;
    got_v = {mem_rd_en, mem_wr_en, done, misalign_err, req_ready, stall};
    checkOutput("rstreq_ctl", 64'(got_v), 64'b000010);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 checkOutput($sformatf("rstreq_nowr%0d", c), 64'(mem_wr_en), 64'd0);
    end
    checkOutput("rstreq_mem", 64'(mem[8]), 64'(ref_mem[8]));
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4]     = 32'hAABBCCDD;
    ref_mem[4] = 32'hAABBCCDD;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_strobes", 64'({mem_rd_en, mem_wr_en, done, misalign_err}), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_ready_stall", 64'({req_ready, stall}), 64'b10);

    applyStimulus(32'h13, 32'h12345678, 2'd0, "byte13");
    checkOutput("plan_byte", 64'(mem[4]), 64'h78BBCCDD);
    applyStimulus(32'h12, 32'h0000BEEF, 2'd1, "half12");
    checkOutput("plan_half", 64'(mem[4]), 64'hBEEFCCDD);
    applyStimulus(32'h14, 32'hDEADBEEF, 2'd2, "word14");
    applyStimulus(32'h11, 32'h12345678, 2'd1, "half11mis");
    applyStimulus(32'h11, 32'h000000AB, 2'd0, "byte11");
    applyStimulus(32'h2E, 32'h87654321, 2'd3, "rsvd");
`ifndef MEM_BYTE_WE_EN
    resetDuringRead();
    applyStimulus(32'h22, 32'h0000007E, 2'd0, "after_rst");
`endif
    resetWithRequest();

    for (int i = 0; i < 40; i++) begin
      s = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      applyStimulus(a, $urandom, s, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
